// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential shift-and-add 8x8 multiplier.
//   WIDTH       : operand width, fixed by the shared 8-bit adder
//   CNT_W       : iteration counter width (8 iterations)
//   mul_state_t : control FSM states
package mul8_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ripplemod.sv
// 8-bit ripple-carry adder built from a chain of full-adder stages.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : 8-bit sum
//   cout : carry out of bit 7
module ripplemod (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[8];

endmodule

// File: rtl/shift_add_mul8.sv
// Sequential 8x8 unsigned multiplier. One shared ripple adder is reused over
// eight shift-and-add iterations to build a 16-bit product.
//   clk, rst                   : clock, synchronous active-high reset
//   start_valid / start_ready  : operand handshake (a, b sampled on accept)
//   busy                       : high while an operation is in RUN or DONE
//   result_valid / result_ready: product handshake
//   product                    : {acc, q}, registered
module shift_add_mul8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product
);

    import mul8_pkg::*;

    // The adder is a fixed 8-bit block, so no other operand width can work.
    if (WIDTH != mul8_pkg::WIDTH) begin : g_width_check
        $error("shift_add_mul8: WIDTH must be 8");
    end

    mul_state_t       state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign addend = q[0] ? m : '0;

    ripplemod u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Right shift of {cout, sum, q}: the carry lands in acc[7]
                    // and the sum LSB moves into the low half.
                    acc <= {cout, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == {CNT_W{1'b1}}) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state == RUN) || (state == DONE);
    assign result_valid = (state == DONE);
    assign product      = {acc, q};

endmodule

// File: tb/tb_shift_add_mul8.sv
// Self-checking bench for shift_add_mul8: table of operand vectors plus
// hand-written reset sequences, with a queue of expected products.
module tb_shift_add_mul8;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] product;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] sb[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        bit          pulse;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[$];

    shift_add_mul8 #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a_in),
        .b            (b_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " start_ready"}, 32'(start_ready), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " result_valid"}, 32'(result_valid), 32'd0);
    endtask

    // One full operation: accept, wait for valid, optional back-pressure, handshake.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                          input bit pulse, input logic [15:0] exp);
        int          lat;
        logic [15:0] want;
        check("pre-accept start_ready", 32'(start_ready), 32'd1);
        result_ready = (hold == 0);
        start_valid  = 1'b1;
        a_in         = av;
        b_in         = bv;
        sb.push_back(exp);
        tick();
        start_valid = 1'b0;
        a_in        = 8'hxx;
        b_in        = 8'hxx;
        check("busy after accept", 32'(busy), 32'd1);
        lat = 0;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd8);
        if (!result_valid) begin
            void'(sb.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check("hold product", 32'(product), 32'(exp));
            check("hold result_valid", 32'(result_valid), 32'd1);
            check("hold start_ready", 32'(start_ready), 32'd0);
            start_valid = pulse && (i == 2);
            a_in        = 8'h77;
            b_in        = 8'h99;
            tick();
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        if (sb.size() == 0) begin
            check("scoreboard empty", 32'd1, 32'd0);
        end else begin
            want = sb.pop_front();
            check("product", 32'(product), 32'(want));
        end
        tick();
        result_ready = 1'b0;
        check_idle("after handshake");
    endtask

    initial begin
        rst          = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a_in         = '0;
        b_in         = '0;

        vecs.push_back('{a: 8'h00, b: 8'h37, hold: 0, pulse: 0, prod: 16'h0000});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, hold: 0, pulse: 0, prod: 16'hFE01});
        vecs.push_back('{a: 8'h0D, b: 8'h0B, hold: 5, pulse: 1, prod: 16'h008F});
        vecs.push_back('{a: 8'h80, b: 8'h02, hold: 0, pulse: 0, prod: 16'h0100});
        vecs.push_back('{a: 8'h12, b: 8'h34, hold: 0, pulse: 0, prod: 16'h03A8});
        vecs.push_back('{a: 8'h01, b: 8'hFF, hold: 1, pulse: 0, prod: 16'h00FF});
        vecs.push_back('{a: 8'hFF, b: 8'h80, hold: 0, pulse: 0, prod: 16'h7F80});
        vecs.push_back('{a: 8'hAA, b: 8'h55, hold: 2, pulse: 1, prod: 16'h3872});

        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset product", 32'(product), 32'h0000);

        // Back-to-back: each op starts on the cycle right after the previous handshake.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].pulse, vecs[i].prod);
        end

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, int'($urandom_range(0, 2)), 1'b0, 16'(ra) * 16'(rb));
        end

        // Reset during iteration 4: operation aborted, nothing presented.
        start_valid = 1'b1;
        a_in        = 8'hAA;
        b_in        = 8'h55;
        tick();
        start_valid  = 1'b0;
        result_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mid-run busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        check("abort product", 32'(product), 32'h0000);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (result_valid) seen = 1'b1;
                tick();
            end
            check("abort no result", 32'(seen), 32'd0);
        end
        result_ready = 1'b0;
        run_op(8'h03, 8'h05, 0, 1'b0, 16'h000F);

        // Reset and start_valid together: operands must not be captured.
        rst         = 1'b1;
        start_valid = 1'b1;
        a_in        = 8'hC3;
        b_in        = 8'h3C;
        tick();
        rst         = 1'b0;
        start_valid = 1'b0;
        check_idle("reset+start");
        check("reset+start product", 32'(product), 32'h0000);
        tick();
        check("reset+start stays idle", 32'(busy), 32'd0);

        run_op(8'h07, 8'h09, 0, 1'b0, 16'h003F);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/shift_add_mul8.md
# shift_add_mul8

Sequential 8×8 unsigned multiplier controller that time-shares a single 8-bit ripple-carry adder across eight shift-and-add iterations to produce a 16-bit product. It sits beside the 8-bit adder datapath and sequences it: it loads operands, steers the adder inputs each cycle, captures the carry-out, and shifts. Operands enter through a valid/ready handshake and the product leaves through a second valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand width. Only 8 is supported because it must equal the shared adder width; elaboration fails otherwise.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  operands `a`/`b` are valid.
- `start_ready`  out  1  block accepts operands; equals (state == IDLE).
- `a`  in  8  multiplicand, sampled only on accept.
- `b`  in  8  multiplier, sampled only on accept.
- `busy`  out  1  high in RUN and DONE.
- `result_valid`  out  1  `product` is valid; equals (state == DONE).
- `result_ready`  in  1  consumer takes the product.
- `product`  out  16  unsigned a×b.

## Operation
- Registers:
  - `m` (8b): multiplicand.
  - `acc` (8b): high half.
  - `q` (8b): multiplier, which becomes the low half.
  - `cnt` (3b).
  - `state`.
- Adder usage: inputs are `acc` and (q[0] ? m : 0); carry-in is tied to 0; outputs are `sum` and `cout`.
- States:
  - **IDLE**: on start_valid && start_ready, set m←a, q←b, acc←0, cnt←0, and go to RUN. start_valid when not ready is ignored.
  - **RUN**, each cycle: {acc,q} ← {cout, sum, q[7:1]}, which is a right shift of the 17-bit {cout,sum,q}. Then cnt←cnt+1. When cnt==7 this cycle, go to DONE.
  - **DONE**: product = {acc,q}, held stable while result_ready is low. On result_ready, go to IDLE.
- `a`, `b` and `start_valid` are don't-care outside IDLE. `result_ready` is don't-care outside DONE.
- Width rules: no overflow is possible because the product is always < 2^16. The adder carry is never dropped; it becomes acc[7] on the shift.
- Reset values:
  - state = IDLE.
  - m, acc, q = 0; cnt = 0.
  - Therefore start_ready = 1, busy = 0, result_valid = 0, product = 0x0000.
- Reset mid-operation (RUN or DONE): the operation is aborted, no result is ever presented, and the reset values apply on the next cycle.
- Reset and start_valid in the same cycle: reset wins and the operands are not captured.

## Timing
- Accept edge E0, in IDLE with start_valid && start_ready.
- Iterations occur at edges E1..E8.
- result_valid goes high after E8, so the latency is 8 cycles from the accept edge to valid.
- Result handshake at edge R: state is IDLE after R, and start_ready is high in the cycle after R.
- Minimum issue interval is 10 cycles: accept, 8 RUN cycles, 1 DONE cycle with result_ready already high. There is a mandatory 1-cycle IDLE bubble between operations; no start is accepted in DONE.
- product is registered, with no combinational path from inputs to outputs. start_ready, busy and result_valid decode state only.
- The adder is a combinational path within one cycle (8 full-adder stages), between register `acc` and register `acc`.

## Structure
- Package `mul8_pkg`:
  - `WIDTH = 8`.
  - `CNT_W = 3`.
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t`.
- Single sub-module: instantiate the team's existing 8-bit ripple adder `ripplemod` once, with cin = 1'b0. Do not re-implement addition with `+`.
- Control FSM and shift registers live in `shift_add_mul8`.
- Target size: roughly 120–160 lines of RTL.

## Test plan
- Reset, then idle: start_ready = 1, busy = 0, result_valid = 0, product = 0x0000.
- a=0x00, b=0x37, result_ready held 1: result_valid rises 8 cycles after accept with product 0x0000, then returns to IDLE.
- a=0xFF, b=0xFF: product 0xFE01. Checks the maximum value and that the carry is propagated every iteration.
- a=0x0D, b=0x0B, result_ready held low for 5 cycles after valid:
  - product stays 0x008F and result_valid stays 1.
  - start_ready stays 0, and a start_valid pulse during this window is ignored.
- a=0x80, b=0x02 followed back-to-back by a=0x12, b=0x34: products 0x0100 then 0x03A8. The second accept occurs exactly 1 cycle after the first result handshake.
- Assert rst at iteration 4 of a=0xAA, b=0x55: result_valid never rises, start_ready = 1 on the next cycle, and a following 0x03×0x05 yields 0x000F.
